// File: rtl/rx_tlp_sender_if.sv
`default_nettype none
// ============================================================================
//  Module      : rx_tlp_sender_if
//  Description : 64-bit TRN TX bus between the TLP sender (master) and the
//                PCIe core transmit port (slave). All strobes active-low.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rx_tlp_sender_if;
    logic [63:0] trn_td;
    logic [7:0]  trn_trem_n;
    logic        trn_tsof_n;
    logic        trn_teof_n;
    logic        trn_tsrc_rdy_n;
    logic        trn_tdst_rdy_n;

    modport master (
        output trn_td,
        output trn_trem_n,
        output trn_tsof_n,
        output trn_teof_n,
        output trn_tsrc_rdy_n,
        input  trn_tdst_rdy_n
    );

    modport slave (
        input  trn_td,
        input  trn_trem_n,
        input  trn_tsof_n,
        input  trn_teof_n,
        input  trn_tsrc_rdy_n,
        output trn_tdst_rdy_n
    );
endinterface
`default_nettype wire

// File: rtl/rx_tlp_sender.sv
`default_nettype none
// ============================================================================
//  Module      : rx_tlp_sender
//  Description : Reads QWORDs from the RX frame buffer and sends them as
//                posted 64-bit MWr TLPs into the current host huge page.
//                Closes a page with a header write, then returns it to the
//                host (ping-pong over two pages).
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_tlp_sender #(
    parameter int BF = 9
) (
    input  wire                 clk,
    input  wire                 reset_n,
    rx_tlp_sender_if.master     trn,
    input  wire  [15:0]         cfg_completer_id,
    input  wire  [63:0]         huge_page_addr_1,
    input  wire  [63:0]         huge_page_addr_2,
    input  wire  [1:0]          huge_page_ready,
    output logic [1:0]          huge_page_unlock,
    output logic [BF:0]         rd_addr,
    input  wire  [63:0]         rd_data,
    output logic [BF:0]         commited_rd_address,
    input  wire                 trigger_tlp,
    output logic                trigger_tlp_ack,
    input  wire                 change_huge_page,
    input  wire                 send_last_tlp_change_huge_page,
    output logic                change_huge_page_ack,
    input  wire  [4:0]          qwords_to_send
);

    localparam int          AW          = BF + 1;
    localparam logic [18:0] OFFSET_INIT = 19'h10;
    localparam logic [9:0]  CLOSE_LEN   = 10'd2;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WAIT_PAGE,
        S_HDR0,
        S_HDR1,
        S_DATA,
        S_ACK,
        S_CHG_HDR0,
        S_CHG_HDR1,
        S_CHG_DATA,
        S_CHG_ACK,
        S_WAIT_LOW
    } state_t;

    typedef enum logic [1:0] {
        REQ_TRIG,
        REQ_CHG,
        REQ_LAST
    } req_t;

    state_t      state_q,      state_d;
    req_t        req_q,        req_d;
    logic [4:0]  qwords_q,     qwords_d;
    logic [4:0]  cnt_q,        cnt_d;
    logic        idx_q,        idx_d;
    logic [18:0] offset_q,     offset_d;
    logic [BF:0] commited_q,   commited_d;
    logic [BF:0] ptr_q,        ptr_d;
    logic [63:0] td_q,         td_d;
    logic        sof_n_q,      sof_n_d;
    logic        eof_n_q,      eof_n_d;
    logic        src_rdy_n_q,  src_rdy_n_d;
    logic        trig_ack_q,   trig_ack_d;
    logic        chg_ack_q,    chg_ack_d;
    logic [1:0]  unlock_q,     unlock_d;

    logic        w_accept;
    logic [63:0] w_base;
    logic [63:0] w_data_addr;
    logic [9:0]  w_len_data;
    logic [63:0] w_hdr0_data;
    logic [63:0] w_hdr0_chg;
    logic [63:0] w_hdr1_data;
    logic [63:0] w_hdr1_chg;
    logic [18:0] w_used_qw;
    logic [63:0] w_close_payload;
    logic        w_req_level;
    logic        w_last_beat;
    logic        w_next_is_last;

    // A beat moves only when both sides of the TRN handshake are asserted
    assign w_accept        = ~src_rdy_n_q & ~trn.trn_tdst_rdy_n;

    assign w_base          = idx_q ? huge_page_addr_2 : huge_page_addr_1;
    assign w_data_addr     = w_base + {42'd0, offset_q, 3'b000};
    assign w_len_data      = {4'd0, qwords_q, 1'b0};

    // MWr 4DW header: fmt=11 (4DW with data), type=0, no TC/attr, byte enables all set
    assign w_hdr0_data     = {3'b011, 19'd0, w_len_data, cfg_completer_id, 8'h00, 4'hF, 4'hF};
    assign w_hdr0_chg      = {3'b011, 19'd0, CLOSE_LEN,  cfg_completer_id, 8'h00, 4'hF, 4'hF};
    assign w_hdr1_data     = {w_data_addr[63:2], 2'b00};
    assign w_hdr1_chg      = {w_base[63:2], 2'b00};

    // Page header carries the number of payload QWORDs written behind it
    assign w_used_qw       = offset_q - OFFSET_INIT;
    assign w_close_payload = {13'd0, w_used_qw, 32'h0000_0001};

    assign w_last_beat     = (cnt_q == (qwords_q - 5'd1));
    assign w_next_is_last  = ((cnt_q + 5'd1) == (qwords_q - 5'd1));

    // Level of whichever request input was accepted, used to avoid re-acceptance
    always_comb begin
        case (req_q)
            REQ_TRIG: w_req_level = trigger_tlp;
            REQ_CHG:  w_req_level = change_huge_page;
            REQ_LAST: w_req_level = send_last_tlp_change_huge_page;
            default:  w_req_level = 1'b0;
        endcase
    end

    // Next-state, beat loading and bookkeeping for the send FSM
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        qwords_d    = qwords_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        offset_d    = offset_q;
        commited_d  = commited_q;
        ptr_d       = ptr_q;
        td_d        = td_q;
        sof_n_d     = sof_n_q;
        eof_n_d     = eof_n_q;
        src_rdy_n_d = src_rdy_n_q;
        trig_ack_d  = 1'b0;
        chg_ack_d   = 1'b0;
        unlock_d    = 2'b00;

        case (state_q)
            S_IDLE: begin
                if (send_last_tlp_change_huge_page) begin
                    req_d    = REQ_LAST;
                    qwords_d = qwords_to_send;
                    state_d  = S_WAIT_PAGE;
                end else if (change_huge_page) begin
                    req_d    = REQ_CHG;
                    state_d  = S_WAIT_PAGE;
                end else if (trigger_tlp) begin
                    req_d    = REQ_TRIG;
                    qwords_d = qwords_to_send;
                    state_d  = S_WAIT_PAGE;
                end
            end

            S_WAIT_PAGE: begin
                if (huge_page_ready[idx_q]) begin
                    src_rdy_n_d = 1'b0;
                    sof_n_d     = 1'b0;
                    eof_n_d     = 1'b1;
                    if (req_q == REQ_CHG) begin
                        td_d    = w_hdr0_chg;
                        state_d = S_CHG_HDR0;
                    end else begin
                        td_d    = w_hdr0_data;
                        state_d = S_HDR0;
                    end
                end
            end

            S_HDR0: begin
                if (w_accept) begin
                    td_d    = w_hdr1_data;
                    sof_n_d = 1'b1;
                    state_d = S_HDR1;
                end
            end

            // rd_data already holds buffer[ptr_q] because rd_addr tracks ptr_d
            S_HDR1: begin
                if (w_accept) begin
                    td_d    = rd_data;
                    ptr_d   = ptr_q + 1'b1;
                    cnt_d   = 5'd0;
                    eof_n_d = (qwords_q != 5'd1);
                    state_d = S_DATA;
                end
            end

            S_DATA: begin
                if (w_accept) begin
                    if (w_last_beat) begin
                        offset_d   = offset_q + 19'(qwords_q);
                        commited_d = commited_q + AW'(qwords_q);
                        if (req_q == REQ_LAST) begin
                            td_d    = w_hdr0_chg;
                            sof_n_d = 1'b0;
                            eof_n_d = 1'b1;
                            state_d = S_CHG_HDR0;
                        end else begin
                            src_rdy_n_d = 1'b1;
                            eof_n_d     = 1'b1;
                            trig_ack_d  = 1'b1;
                            state_d     = S_ACK;
                        end
                    end else begin
                        td_d    = rd_data;
                        ptr_d   = ptr_q + 1'b1;
                        cnt_d   = cnt_q + 5'd1;
                        eof_n_d = ~w_next_is_last;
                    end
                end
            end

            S_ACK: begin
                state_d = S_WAIT_LOW;
            end

            S_CHG_HDR0: begin
                if (w_accept) begin
                    td_d    = w_hdr1_chg;
                    sof_n_d = 1'b1;
                    state_d = S_CHG_HDR1;
                end
            end

            S_CHG_HDR1: begin
                if (w_accept) begin
                    td_d    = w_close_payload;
                    eof_n_d = 1'b0;
                    state_d = S_CHG_DATA;
                end
            end

            S_CHG_DATA: begin
                if (w_accept) begin
                    src_rdy_n_d = 1'b1;
                    eof_n_d     = 1'b1;
                    unlock_d    = idx_q ? 2'b10 : 2'b01;
                    idx_d       = ~idx_q;
                    offset_d    = OFFSET_INIT;
                    chg_ack_d   = 1'b1;
                    state_d     = S_CHG_ACK;
                end
            end

            S_CHG_ACK: begin
                state_d = S_WAIT_LOW;
            end

            S_WAIT_LOW: begin
                if (!w_req_level) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any TLP in flight immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            req_q       <= REQ_TRIG;
            qwords_q    <= 5'd0;
            cnt_q       <= 5'd0;
            idx_q       <= 1'b0;
            offset_q    <= OFFSET_INIT;
            commited_q  <= '0;
            ptr_q       <= '0;
            td_q        <= 64'd0;
            sof_n_q     <= 1'b1;
            eof_n_q     <= 1'b1;
            src_rdy_n_q <= 1'b1;
            trig_ack_q  <= 1'b0;
            chg_ack_q   <= 1'b0;
            unlock_q    <= 2'b00;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            qwords_q    <= qwords_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            offset_q    <= offset_d;
            commited_q  <= commited_d;
            ptr_q       <= ptr_d;
            td_q        <= td_d;
            sof_n_q     <= sof_n_d;
            eof_n_q     <= eof_n_d;
            src_rdy_n_q <= src_rdy_n_d;
            trig_ack_q  <= trig_ack_d;
            chg_ack_q   <= chg_ack_d;
            unlock_q    <= unlock_d;
        end
    end

    // Presenting the next pointer lets the 1-cycle buffer read land exactly when
    // the beat is loaded, giving back-to-back beats and stable data under stalls
    assign rd_addr              = ptr_d;

    assign trn.trn_td           = td_q;
    assign trn.trn_trem_n       = 8'h00;
    assign trn.trn_tsof_n       = sof_n_q;
    assign trn.trn_teof_n       = eof_n_q;
    assign trn.trn_tsrc_rdy_n   = src_rdy_n_q;

    assign commited_rd_address  = commited_q;
    assign trigger_tlp_ack      = trig_ack_q;
    assign change_huge_page_ack = chg_ack_q;
    assign huge_page_unlock     = unlock_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_tlp_sender.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rx_tlp_sender
//  Description : Scoreboard bench for rx_tlp_sender. Requests push expected
//                TRN beats and ack events; a monitor pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_tlp_sender;

    localparam int BF      = 6;
    localparam int N       = 1 << (BF + 1);
    localparam int TIMEOUT = 2000;
    localparam int K_TRIG  = 0;
    localparam int K_CHG   = 1;
    localparam int K_LAST  = 2;
    localparam logic [15:0] CID = 16'hBEEF;

    typedef struct packed {
        logic [63:0] td;
        logic        sof;
        logic        eof;
    } beat_t;

    typedef struct packed {
        logic        is_chg;
        logic [1:0]  unlock;
        logic [BF:0] commited;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] cfg_completer_id = CID;
    logic [63:0] huge_page_addr_1 = 64'h0000_0012_3400_0000;
    logic [63:0] huge_page_addr_2 = 64'h0000_00AB_CDE0_0000;
    logic [1:0]  huge_page_ready;
    logic [1:0]  huge_page_unlock;
    logic [BF:0] rd_addr;
    logic [63:0] rd_data;
    logic [BF:0] commited_rd_address;
    logic        trigger_tlp = 1'b0;
    logic        trigger_tlp_ack;
    logic        change_huge_page = 1'b0;
    logic        send_last_tlp_change_huge_page = 1'b0;
    logic        change_huge_page_ack;
    logic [4:0]  qwords_to_send = 5'd0;

    logic        ready0 = 1'b0;
    logic        ready1 = 1'b0;
    logic        arm_go = 1'b0;
    int          dmode = 0;

    logic [63:0] mem [N];
    beat_t       exp_q[$];
    ev_t         ev_q[$];

    int          n_checks = 0;
    int          n_pass = 0;
    int          beats_seen = 0;

    int          m_idx;
    int          m_offset;
    int          m_commited;
    logic [63:0] m_base [2];

    rx_tlp_sender_if trn_if();

    rx_tlp_sender #(.BF(BF)) dut (
        .clk                            (clk),
        .reset_n                        (reset_n),
        .trn                            (trn_if),
        .cfg_completer_id               (cfg_completer_id),
        .huge_page_addr_1               (huge_page_addr_1),
        .huge_page_addr_2               (huge_page_addr_2),
        .huge_page_ready                (huge_page_ready),
        .huge_page_unlock               (huge_page_unlock),
        .rd_addr                        (rd_addr),
        .rd_data                        (rd_data),
        .commited_rd_address            (commited_rd_address),
        .trigger_tlp                    (trigger_tlp),
        .trigger_tlp_ack                (trigger_tlp_ack),
        .change_huge_page               (change_huge_page),
        .send_last_tlp_change_huge_page (send_last_tlp_change_huge_page),
        .change_huge_page_ack           (change_huge_page_ack),
        .qwords_to_send                 (qwords_to_send)
    );

    always #5 clk = ~clk;

    assign huge_page_ready = {ready1, ready0};

    // Frame buffer with one cycle of read latency
    always @(posedge clk) rd_data <= mem[rd_addr];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail_now(input string name, input logic [63:0] act);
        n_checks++;
        $display("FAIL %s: got %h expected nothing", name, act);
    endtask

    function automatic logic [63:0] hdr0(input int len);
        return {32'h6000_0000 + 32'(len), CID, 16'h00FF};
    endfunction

    // Reference model: what a request must put on the bus, from the page rules
    task automatic model_push(input int kind, input int q);
        logic [63:0] addr;
        if (kind != K_CHG) begin
            addr = m_base[m_idx] + 64'(m_offset) * 64'd8;
            exp_q.push_back('{td: hdr0(q * 2), sof: 1'b1, eof: 1'b0});
            exp_q.push_back('{td: addr, sof: 1'b0, eof: 1'b0});
            for (int i = 0; i < q; i++)
                exp_q.push_back('{td: mem[(m_commited + i) % N], sof: 1'b0, eof: (i == q - 1)});
            m_offset   = m_offset + q;
            m_commited = (m_commited + q) % N;
            if (kind == K_TRIG)
                ev_q.push_back('{is_chg: 1'b0, unlock: 2'b00, commited: (BF+1)'(m_commited)});
        end
        if (kind != K_TRIG) begin
            exp_q.push_back('{td: hdr0(2), sof: 1'b1, eof: 1'b0});
            exp_q.push_back('{td: m_base[m_idx], sof: 1'b0, eof: 1'b0});
            exp_q.push_back('{td: {32'(m_offset - 16), 32'h0000_0001}, sof: 1'b0, eof: 1'b1});
            ev_q.push_back('{is_chg: 1'b1, unlock: (m_idx == 0) ? 2'b01 : 2'b10,
                             commited: (BF+1)'(m_commited)});
            m_idx    = 1 - m_idx;
            m_offset = 16;
        end
    endtask

    task automatic model_reset();
        m_idx      = 0;
        m_offset   = 16;
        m_commited = 0;
    endtask

    task automatic set_req(input int kind, input logic v);
        case (kind)
            K_TRIG:  trigger_tlp = v;
            K_CHG:   change_huge_page = v;
            default: send_last_tlp_change_huge_page = v;
        endcase
    endtask

    task automatic start_req(input int kind, input int q);
        qwords_to_send = 5'(q);
        model_push(kind, q);
        set_req(kind, 1'b1);
    endtask

    // Wait for the ack, hold 2 more cycles, then drop the request for one cycle
    task automatic finish_req(input int kind);
        logic got;
        got = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) begin
            @(posedge clk); #1;
            if ((kind == K_TRIG) ? trigger_tlp_ack : change_huge_page_ack) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) fail_now("ack_timeout", 64'(kind));
        repeat (2) @(posedge clk);
        #1 set_req(kind, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic do_req(input int kind, input int q);
        start_req(kind, q);
        finish_req(kind);
    endtask

    // Backpressure generator
    initial begin
        trn_if.trn_tdst_rdy_n = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (dmode)
                0:       trn_if.trn_tdst_rdy_n = 1'b0;
                1:       trn_if.trn_tdst_rdy_n = ~trn_if.trn_tdst_rdy_n;
                default: trn_if.trn_tdst_rdy_n = ($urandom_range(0, 2) == 0);
            endcase
        end
    end

    // Host arming page 0: re-arms some cycles after each unlock
    initial begin
        wait (arm_go);
        ready0 = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (huge_page_unlock[0]) begin
                ready0 = 1'b0;
                repeat ($urandom_range(3, 20)) @(posedge clk);
                #1 ready0 = 1'b1;
            end
        end
    end

    // Host arming page 1
    initial begin
        wait (arm_go);
        ready1 = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (huge_page_unlock[1]) begin
                ready1 = 1'b0;
                repeat ($urandom_range(3, 20)) @(posedge clk);
                #1 ready1 = 1'b1;
            end
        end
    end

    // Monitor: compare every accepted beat and every ack pulse with the scoreboard
    initial begin
        beat_t b;
        ev_t   e;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (!trn_if.trn_tsrc_rdy_n && !trn_if.trn_tdst_rdy_n) begin
                    beats_seen++;
                    chk("trem_n", 64'(trn_if.trn_trem_n), 64'h0);
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_beat", trn_if.trn_td);
                    end else begin
                        b = exp_q.pop_front();
                        chk("beat_td", trn_if.trn_td, b.td);
                        chk("beat_sof_eof", 64'({~trn_if.trn_tsof_n, ~trn_if.trn_teof_n}),
                            64'({b.sof, b.eof}));
                    end
                end
                if (trigger_tlp_ack || change_huge_page_ack) begin
                    if (ev_q.size() == 0) begin
                        fail_now("unexpected_ack", 64'({trigger_tlp_ack, change_huge_page_ack}));
                    end else begin
                        e = ev_q.pop_front();
                        chk("ack_kind", 64'({trigger_tlp_ack, change_huge_page_ack}),
                            64'({~e.is_chg, e.is_chg}));
                        chk("commited_rd_address", 64'(commited_rd_address), 64'(e.commited));
                        chk("unlock", 64'(huge_page_unlock), 64'(e.unlock));
                    end
                end else if (huge_page_unlock != 2'b00) begin
                    fail_now("stray_unlock", 64'(huge_page_unlock));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int target;
        int kind;
        int q;
        logic hit;

        for (int i = 0; i < N; i++) mem[i] = {$urandom, $urandom};
        m_base[0] = huge_page_addr_1;
        m_base[1] = huge_page_addr_2;
        model_reset();

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tsrc_rdy_n", 64'(trn_if.trn_tsrc_rdy_n), 64'h1);
        chk("rst_tsof_teof", 64'({trn_if.trn_tsof_n, trn_if.trn_teof_n}), 64'h3);
        chk("rst_td", trn_if.trn_td, 64'h0);
        chk("rst_acks_unlock", 64'({trigger_tlp_ack, change_huge_page_ack, huge_page_unlock}), 64'h0);
        chk("rst_rd_addr", 64'(rd_addr), 64'h0);
        chk("rst_commited", 64'(commited_rd_address), 64'h0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Page not armed: nothing may be sent
        start_req(K_TRIG, 16);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("wait_page_idle", 64'(trn_if.trn_tsrc_rdy_n), 64'h1);
        end
        arm_go = 1'b1;
        finish_req(K_TRIG);

        // Page close with last TLP, then next TLP into page 1
        do_req(K_LAST, 5);
        do_req(K_TRIG, 4);

        // Toggling backpressure, back-to-back identical requests
        dmode = 1;
        do_req(K_TRIG, 16);
        do_req(K_TRIG, 1);
        do_req(K_TRIG, 7);
        do_req(K_CHG, 1);
        do_req(K_CHG, 1);

        // Randomized traffic
        dmode = 2;
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 9);
            kind = (kind < 7) ? K_TRIG : ((kind < 9) ? K_LAST : K_CHG);
            q    = $urandom_range(1, 16);
            do_req(kind, q);
        end

        // Drive the read pointer to 8 below the wrap point, then cross it
        dmode = 0;
        while (m_commited != N - 8) begin
            q = (N - 8 - m_commited + N) % N;
            do_req(K_TRIG, (q > 16) ? 16 : q);
        end
        do_req(K_TRIG, 16);

        // Reset while the third data beat is on the bus
        target = beats_seen + 4;
        start_req(K_TRIG, 16);
        hit = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) begin
            @(posedge clk); #1;
            if (beats_seen >= target) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) fail_now("reset_point_timeout", 64'(beats_seen));
        reset_n = 1'b0;
        #1;
        chk("abort_tsrc_rdy_n", 64'(trn_if.trn_tsrc_rdy_n), 64'h1);
        chk("abort_tsof_teof", 64'({trn_if.trn_tsof_n, trn_if.trn_teof_n}), 64'h3);
        chk("abort_td", trn_if.trn_td, 64'h0);
        chk("abort_rd_addr", 64'(rd_addr), 64'h0);
        chk("abort_commited", 64'(commited_rd_address), 64'h0);
        trigger_tlp = 1'b0;
        exp_q.delete();
        ev_q.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;

        // Traffic after the abort restarts from the reset state
        dmode = 2;
        for (int n = 0; n < 8; n++) begin
            kind = ($urandom_range(0, 3) == 0) ? K_LAST : K_TRIG;
            do_req(kind, $urandom_range(1, 16));
        end

        repeat (5) @(posedge clk);
        #1;
        chk("beats_drained", 64'(exp_q.size()), 64'h0);
        chk("events_drained", 64'(ev_q.size()), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
